axil_target_regs: RTL and testbench
===================================

Name: axil_target_regs

Overview:
- AXI4-Lite subordinate register file that sits directly downstream of the MyManager M00_AXI master.
- It accepts the master's write/read burst of single-beat transactions and stores NUM_REGS 32-bit words.
- It returns OKAY/SLVERR responses, and presents the register contents and per-register write strobes to fabric logic.
- It replaces the BFM slave VIP when MyManager is integrated with real hardware.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 5, AXI byte-address width.
- NUM_REGS, 4, number of implemented registers (1..2**(ADDR_WIDTH-2)).

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read-address handshake.
- S_AXI_RDATA  out  DATA_WIDTH / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read response.
- reg_q  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i occupies bits [i*32 +: 32].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse when register i is written.

Behaviour:
- Clocking and reset: one clock, S_AXI_ACLK. Reset is synchronous, active-low (S_AXI_ARESETN sampled on the rising edge).
- Reset values:
  - all registers 0.
  - BVALID=0, RVALID=0, BRESP=RRESP=2'b00, RDATA=0.
  - reg_wr_pulse=0.
  - both FSMs return to idle.
- Reset mid-transaction: any pending response is discarded.
- Address decode: idx = addr[ADDR_WIDTH-1:2]. The low 2 bits are ignored. idx >= NUM_REGS is out of range.
- Write FSM, states WR_IDLE, WR_NEED_W, WR_NEED_AW, WR_RESP. AWREADY and WREADY are decoded from the registered state.
  - WR_IDLE: AWREADY=WREADY=1.
    - AWVALID&WVALID: commit the write on this edge, go to WR_RESP.
    - Only AWVALID: latch address, go to WR_NEED_W.
    - Only WVALID: latch data and strobes, go to WR_NEED_AW.
  - WR_NEED_W: AWREADY=0, WREADY=1. On WVALID, commit and go to WR_RESP.
  - WR_NEED_AW: AWREADY=1, WREADY=0. On AWVALID, commit and go to WR_RESP.
  - WR_RESP: BVALID=1 and AWREADY=WREADY=0. Hold BVALID/BRESP until BREADY, then go to WR_IDLE. No back-to-back write acceptance in the same cycle as B completion.
- Commit rules:
  - Each byte b where WSTRB[b]=1 updates reg[idx][8b+7:8b].
  - reg_q reflects the new value the cycle after the commit edge.
  - reg_wr_pulse[idx] is high for exactly that cycle, even when WSTRB=0.
  - Out-of-range writes change nothing and produce no pulse.
- Read FSM, states RD_IDLE, RD_RESP:
  - RD_IDLE: ARREADY=1. On ARVALID, register RDATA=reg[idx] (0 if out of range) and RRESP, go to RD_RESP.
  - RD_RESP: ARREADY=0, RVALID=1. Hold RDATA/RRESP until RREADY, then go to RD_IDLE.
  - Read latency: RVALID asserts one cycle after the AR handshake.
- Read and write are independent. If a read handshake and a write commit to the same register occur on the same edge, RDATA returns the pre-write value.
- BRESP/RRESP are OKAY (2'b00) for in-range accesses.

Optional Feature:
- Macro: AXIL_TARGET_SLVERR_EN.
- Defined: out-of-range accesses return BRESP/RRESP=2'b10 (SLVERR), and out-of-range reads return RDATA=0.
- Undefined: out-of-range accesses return OKAY, writes are silently dropped, and reads return 0.
- In-range behaviour is identical in both builds.

Decomposition:
- Package axil_target_pkg:
  - resp enum (OKAY=2'b00, SLVERR=2'b10).
  - wr_state_t and rd_state_t enums.
  - ADDR_LSB=2 constant.
  - function index_in_range(idx, NUM_REGS).
- One natural sub-module: axil_target_byte_wr, which applies WSTRB to a 32-bit word.
- The read path stays inline.

Test Plan:
- Manager pattern: AW+W together to 0x00, 0x04, 0x08, 0x0C with data 0x00000001..0x00000004, WSTRB=4'hF, BREADY=1 → four OKAY B responses, each one cycle after commit; reg_q = {4,3,2,1}; one reg_wr_pulse per register. Then read 0x00..0x0C → RDATA 1..4, RRESP=OKAY, RVALID one cycle after ARREADY.
- Channel skew: AWVALID to 0x08 at cycle 0, WVALID 0xDEADBEEF at cycle 3 → AWREADY drops after cycle 0; reg2=0xDEADBEEF after cycle 3; BVALID at cycle 4. Repeat with W leading AW.
- Byte strobes and backpressure: reg1=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 → reg1=0xFF34FF78. Hold BREADY=0 for 5 cycles → BVALID and BRESP stable, AWREADY=WREADY=0 throughout.
- Out of range: write 0x10 with 0xA5A5A5A5, then read 0x10.
  - With AXIL_TARGET_SLVERR_EN: BRESP=RRESP=2'b10, RDATA=0.
  - Without it: both responses OKAY, RDATA=0.
  - In both builds regs are unchanged and reg_wr_pulse stays 0.
- Same-edge read/write: reg0=0x11, write 0x22 to 0x00 on the same edge as an AR to 0x00 → RDATA=0x11; a following read returns 0x22.
- Reset mid-transaction: deassert S_AXI_ARESETN while BVALID=1 and RVALID=1, hold RREADY=0 → next edge gives BVALID=RVALID=0, reg_q=0, AWREADY=WREADY=ARREADY=1 after release.

Source files
------------

// File: rtl/axil_target_pkg.sv
// Shared types and helpers for the AXI4-Lite target register file.
// Response codes, FSM encodings and address-decode helpers.
package axil_target_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_NEED_W,
    WR_NEED_AW,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  localparam int ADDR_LSB = 2;

  function automatic logic index_in_range(
    input int idx,
    input int num_regs
  );
    return idx < num_regs;
  endfunction

endpackage

// File: rtl/axil_target_byte_wr.sv
// Byte-lane merge: applies a write strobe mask to one register word.
// Lanes with strb_i[b]=0 keep the old byte.
module axil_target_byte_wr #(
  parameter int DW = 32
) (
  input  logic [DW-1:0]   word_i,
  input  logic [DW-1:0]   data_i,
  input  logic [DW/8-1:0] strb_i,
  output logic [DW-1:0]   word_o
);

  // Per-lane select between old and new byte
  always_comb begin
    word_o = word_i;
    for (int b = 0; b < DW/8; b++) begin
      if (strb_i[b]) begin
        word_o[8*b +: 8] = data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axil_target_regs.sv
// AXI4-Lite target register file with per-register write pulses.
// Build option: AXIL_TARGET_SLVERR_EN returns SLVERR for out-of-range.
module axil_target_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  import axil_target_pkg::*;

  localparam int IW = ADDR_WIDTH - ADDR_LSB;
  localparam int SW = DATA_WIDTH / 8;

  wr_state_t wr_state_q;
  rd_state_t rd_state_q;

  logic [IW-1:0]         aw_idx;
  logic [IW-1:0]         ar_idx;
  logic [IW-1:0]         awidx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic                  bvalid_q;
  resp_t                 bresp_q;
  logic                  rvalid_q;
  resp_t                 rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] word_d [NUM_REGS];
  logic [NUM_REGS-1:0]   hit;
  logic [NUM_REGS-1:0]   pulse_q;

  logic                  commit;
  logic [IW-1:0]         c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic [SW-1:0]         c_strb;
  logic [DATA_WIDTH-1:0] rd_word;
  resp_t                 wr_resp;
  resp_t                 rd_resp;
  logic                  unused_ok;

  assign aw_idx = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0]};

  assign S_AXI_AWREADY = (wr_state_q == WR_IDLE) ||
                         (wr_state_q == WR_NEED_AW);
  assign S_AXI_WREADY  = (wr_state_q == WR_IDLE) ||
                         (wr_state_q == WR_NEED_W);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rd_state_q == RD_IDLE);
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_wr_pulse  = pulse_q;

  // Select the commit source: live channel or the half latched earlier
  always_comb begin
    commit = 1'b0;
    c_idx  = aw_idx;
    c_data = S_AXI_WDATA;
    c_strb = S_AXI_WSTRB;
    unique case (wr_state_q)
      WR_IDLE: begin
        commit = S_AXI_AWVALID && S_AXI_WVALID;
      end
      WR_NEED_W: begin
        commit = S_AXI_WVALID;
        c_idx  = awidx_q;
      end
      WR_NEED_AW: begin
        commit = S_AXI_AWVALID;
        c_data = wdata_q;
        c_strb = wstrb_q;
      end
      default: begin
        commit = 1'b0;
      end
    endcase
  end

`ifdef AXIL_TARGET_SLVERR_EN
  logic c_in_range;
  logic ar_in_range;
  assign c_in_range  = index_in_range(32'(c_idx), NUM_REGS);
  assign ar_in_range = index_in_range(32'(ar_idx), NUM_REGS);
  assign wr_resp = c_in_range  ? RESP_OKAY : RESP_SLVERR;
  assign rd_resp = ar_in_range ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_resp = RESP_OKAY;
  assign rd_resp = RESP_OKAY;
`endif

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    axil_target_byte_wr #(
      .DW (DATA_WIDTH)
    ) u_byte_wr (
      .word_i (regs_q[i]),
      .data_i (c_data),
      .strb_i (c_strb),
      .word_o (word_d[i])
    );
    assign hit[i] = commit && (c_idx == IW'(i));
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  // Read mux; unmatched (out-of-range) indices read as zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IW'(i)) begin
        rd_word = regs_q[i];
      end
    end
  end

  // Register storage and the one-cycle write pulses
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      pulse_q <= '0;
    end else begin
      pulse_q <= hit;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (hit[i]) begin
          regs_q[i] <= word_d[i];
        end
      end
    end
  end

  // Write FSM: pairs AW and W in any order, then holds B until taken
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= WR_IDLE;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else if (commit) begin
      wr_state_q <= WR_RESP;
      bvalid_q   <= 1'b1;
      bresp_q    <= wr_resp;
    end else begin
      unique case (wr_state_q)
        WR_IDLE: begin
          if (S_AXI_AWVALID) begin
            awidx_q    <= aw_idx;
            wr_state_q <= WR_NEED_W;
          end else if (S_AXI_WVALID) begin
            wdata_q    <= S_AXI_WDATA;
            wstrb_q    <= S_AXI_WSTRB;
            wr_state_q <= WR_NEED_AW;
          end
        end
        WR_NEED_W: begin
          wr_state_q <= WR_NEED_W;
        end
        WR_NEED_AW: begin
          wr_state_q <= WR_NEED_AW;
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: begin
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Read FSM: capture data on AR, hold R until taken
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      unique case (rd_state_q)
        RD_IDLE: begin
          if (S_AXI_ARVALID) begin
            rdata_q    <= rd_word;
            rresp_q    <= rd_resp;
            rvalid_q   <= 1'b1;
            rd_state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: begin
          rd_state_q <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_target_regs.sv
// Self-checking bench for axil_target_regs.
// Directed scenarios plus randomized traffic against a word-array model.
module tb_axil_target_regs;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;

`ifdef AXIL_TARGET_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [NR*DW-1:0] regq;
  logic [NR-1:0] pulse;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] mdl [NR];

  always #5 clk = ~clk;

  axil_target_regs #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NR)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_q         (regq),
    .reg_wr_pulse  (pulse)
  );

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NR*DW-1:0] mdl_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // skew > 0: AW leads W by skew cycles; skew < 0: W leads AW
  task automatic do_write(
    input logic [AW-1:0] addr,
    input logic [31:0]   data,
    input logic [3:0]    strb,
    input int            skew,
    input int            bhold
  );
    int          idx;
    bit          inr;
    int          aw_at;
    int          w_at;
    int          cyc;
    bit          aw_done;
    bit          w_done;
    bit          aw_hs;
    bit          w_hs;
    logic [1:0]  er;
    logic [NR-1:0] ep;
    idx   = int'(addr[AW-1:2]);
    inr   = idx < NR;
    aw_at = (skew < 0) ? -skew : 0;
    w_at  = (skew > 0) ? skew : 0;
    er    = inr ? 2'b00 : OOR_RESP;
    ep    = inr ? (NR'(1) << idx) : '0;
    cyc   = 0;
    aw_done = 0;
    w_done  = 0;
    bready  = (bhold == 0);
    while (!(aw_done && w_done)) begin
      if (cyc > 20) begin
        check("wr_timeout", 0, 1);
        awvalid = 0;
        wvalid  = 0;
        return;
      end
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = (cyc >= aw_at) && !aw_done;
      wvalid  = (cyc >= w_at) && !w_done;
      if (aw_done) check("awready_wait", awready, 0);
      if (w_done)  check("wready_wait", wready, 0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
    end
    awvalid = 0;
    wvalid  = 0;
    if (inr) mdl[idx] = merge(mdl[idx], data, strb);
    check("bvalid", bvalid, 1);
    check("bresp", bresp, er);
    check("reg_q", regq, mdl_flat());
    check("pulse", pulse, ep);
    check("awready_b", awready, 0);
    check("wready_b", wready, 0);
    for (int k = 0; k < bhold; k++) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, er);
      check("aw_w_ready_hold", {awready, wready}, 2'b00);
      check("pulse_hold", pulse, 0);
    end
    bready = 1;
    @(negedge clk);
    check("bvalid_done", bvalid, 0);
    check("pulse_done", pulse, 0);
  endtask

  task automatic do_read(
    input logic [AW-1:0] addr,
    input int            rhold
  );
    int          idx;
    bit          inr;
    logic [31:0] ed;
    logic [1:0]  er;
    idx = int'(addr[AW-1:2]);
    inr = idx < NR;
    ed  = inr ? mdl[idx] : 32'h0;
    er  = inr ? 2'b00 : OOR_RESP;
    rready  = (rhold == 0);
    araddr  = addr;
    arvalid = 1;
    check("arready", arready, 1);
    @(negedge clk);
    arvalid = 0;
    check("rvalid", rvalid, 1);
    check("rdata", rdata, ed);
    check("rresp", rresp, er);
    check("arready_r", arready, 0);
    for (int k = 0; k < rhold; k++) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, ed);
    end
    rready = 1;
    @(negedge clk);
    check("rvalid_done", rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn    = 0;
    awaddr  = '0;
    awprot  = 3'b010;
    awvalid = 0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 0;
    bready  = 1;
    araddr  = '0;
    arprot  = 3'b001;
    arvalid = 0;
    rready  = 1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_regq", regq, 0);
    check("rst_pulse", pulse, 0);
    rstn = 1;
    @(negedge clk);
    check("rst_ready", {awready, wready, arready}, 3'b111);

    // Manager pattern
    for (int i = 0; i < NR; i++)
      do_write(AW'(i * 4), 32'(i + 1), 4'hF, 0, 0);
    check("mgr_regq", regq, 128'h00000004_00000003_00000002_00000001);
    for (int i = 0; i < NR; i++) do_read(AW'(i * 4), 0);

    // Channel skew both ways
    do_write(5'h08, 32'hDEADBEEF, 4'hF, 3, 0);
    check("skew_reg2", regq[95:64], 32'hDEADBEEF);
    do_write(5'h04, 32'hCAFEF00D, 4'hF, -3, 0);
    check("skew_reg1", regq[63:32], 32'hCAFEF00D);

    // Byte strobes with B backpressure
    do_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(5'h04, 32'h12345678, 4'b0101, 0, 5);
    check("strb_reg1", regq[63:32], 32'hFF34FF78);

    // Zero strobe still pulses
    do_write(5'h0C, 32'h55555555, 4'h0, 0, 0);

    // Out of range
    do_write(5'h10, 32'hA5A5A5A5, 4'hF, 0, 0);
    do_read(5'h10, 0);
    do_read(5'h1F, 2);

    // Same-edge read and write to reg0
    do_write(5'h00, 32'h11, 4'hF, 0, 0);
    awaddr  = 5'h00;
    wdata   = 32'h22;
    wstrb   = 4'hF;
    awvalid = 1;
    wvalid  = 1;
    araddr  = 5'h00;
    arvalid = 1;
    @(negedge clk);
    awvalid = 0;
    wvalid  = 0;
    arvalid = 0;
    mdl[0]  = 32'h22;
    check("same_rdata", rdata, 32'h11);
    check("same_bvalid", bvalid, 1);
    check("same_rvalid", rvalid, 1);
    check("same_regq", regq, mdl_flat());
    @(negedge clk);
    do_read(5'h00, 0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom),
                 int'($urandom_range(0, 6)) - 3,
                 int'($urandom_range(0, 2)));
      else
        do_read(a, int'($urandom_range(0, 2)));
    end

    // Reset with both responses pending
    bready  = 0;
    rready  = 0;
    awaddr  = 5'h04;
    wdata   = 32'h77;
    wstrb   = 4'hF;
    awvalid = 1;
    wvalid  = 1;
    araddr  = 5'h08;
    arvalid = 1;
    @(negedge clk);
    awvalid = 0;
    wvalid  = 0;
    arvalid = 0;
    check("pre_rst_valid", {bvalid, rvalid}, 2'b11);
    rstn = 0;
    @(negedge clk);
    check("mid_rst_valid", {bvalid, rvalid}, 2'b00);
    check("mid_rst_regq", regq, 0);
    rstn   = 1;
    bready = 1;
    rready = 1;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    @(negedge clk);
    check("post_rst_ready", {awready, wready, arready}, 3'b111);
    check("post_rst_valid", {bvalid, rvalid}, 2'b00);
    do_read(5'h04, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
